// File: rtl/dmem_sram_bridge_pkg.sv
// Shared size codes, FSM state encodings and the alignment rule for the data-memory bridge.
package dmem_sram_bridge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Size code 11 behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram_bridge_align.sv
// Combinational lane logic: store byte strobes, lane-replicated store data,
// and lane selection plus sign/zero extension of load data.
module dmem_sram_bridge_align
    import dmem_sram_bridge_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_store,
    input  logic        is_unsigned,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        ext_bit;

    always_comb begin
        wstrb = 4'b0000;
        wdata = wd;
        case (size)
            SZ_BYTE: begin
                if (is_store) wstrb = 4'b0001 << addr_lo;
                wdata = {4{wd[7:0]}};
            end
            SZ_HALF: begin
                if (is_store) wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{wd[15:0]}};
            end
            default: begin
                if (is_store) wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ext_bit   = 1'b0;
        rdata_ext = rdata;
        case (size)
            SZ_BYTE: begin
                ext_bit   = ~is_unsigned & byte_sel[7];
                rdata_ext = {{24{ext_bit}}, byte_sel};
            end
            SZ_HALF: begin
                ext_bit   = ~is_unsigned & half_sel[15];
                rdata_ext = {{16{ext_bit}}, half_sel};
            end
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_sram_bridge.sv
// M-stage to SRAM-like bus bridge: one outstanding req/addr_ok/data_ok transaction,
// pipeline stall until the data phase completes, misalignment faults.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no access in flight; a valid M-stage access starts here
//  ADDR    | data_req high, waiting for data_addr_ok
//  DATA    | address accepted, waiting for data_data_ok
//  DONE    | access complete, rdata_q held until the pipeline advances
module dmem_sram_bridge
    import dmem_sram_bridge_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enM,
    input  logic        memwriteM,
    input  logic [1:0]  sizeM,
    input  logic        unsignedM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        advanceM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] rdata_q;
    logic        misalign;
    logic        fault;
    logic [1:0]  addr_lo;
    logic        data_done;

    assign misalign = is_misaligned(sizeM, aluoutM[1:0]);
    assign fault    = ALIGN_CHECK & mem_enM & misalign;
    assign adelM    = fault & ~memwriteM;
    assign adesM    = fault & memwriteM;

    // With the check disabled, misaligned addresses are silently rounded down to the access size.
    always_comb begin
        addr_lo = aluoutM[1:0];
        if (!ALIGN_CHECK) begin
            case (sizeM)
                SZ_BYTE: addr_lo = aluoutM[1:0];
                SZ_HALF: addr_lo = {aluoutM[1], 1'b0};
                default: addr_lo = 2'b00;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mem_enM && !fault) state_nxt = ST_ADDR;
            ST_ADDR: if (data_addr_ok) state_nxt = data_data_ok ? ST_DONE : ST_DATA;
            ST_DATA: if (data_data_ok) state_nxt = ST_DONE;
            ST_DONE: if (advanceM) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // data_ok seen in IDLE or DONE is spurious and must not disturb rdata_q.
    assign data_done = ((state == ST_ADDR) && data_addr_ok && data_data_ok) ||
                       ((state == ST_DATA) && data_data_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            rdata_q <= 32'h0;
        end else begin
            state <= state_nxt;
            if (data_done) rdata_q <= data_rdata;
        end
    end

    assign stallM    = mem_enM & ~fault & (state != ST_DONE);
    assign data_req  = (state == ST_ADDR);
    assign data_wr   = memwriteM;
    assign data_size = sizeM;
    assign data_addr = {aluoutM[31:2], addr_lo};

    dmem_sram_bridge_align u_mem_align_unit (
        .addr_lo     (addr_lo),
        .size        (sizeM),
        .is_store    (memwriteM),
        .is_unsigned (unsignedM),
        .wd          (writedataM),
        .rdata       (rdata_q),
        .wstrb       (data_wstrb),
        .wdata       (data_wdata),
        .rdata_ext   (readdataM)
    );

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Bench for dmem_sram_bridge: directed accesses against a byte-lane model of the bus bridge.
module tb_dmem_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_enM, memwriteM, unsignedM, advanceM;
    logic [1:0]  sizeM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, adelM, adesM;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_vec = 0;
    int n_err = 0;
    int req_cnt = 0;
    logic prev_req = 1'b0;

    logic        chk_en = 1'b0;
    logic        m_stall = 1'b0, m_req = 1'b0, m_rd_en = 1'b0;
    logic [31:0] m_rd = 32'h0;
    logic        lit_rd_en = 1'b0, lit_wr_en = 1'b0;
    logic [31:0] lit_rd = 32'h0, lit_wdata = 32'h0;
    logic [3:0]  lit_strb = 4'h0;

    always #5 clk = ~clk;

    dmem_sram_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .mem_enM      (mem_enM),
        .memwriteM    (memwriteM),
        .sizeM        (sizeM),
        .unsignedM    (unsignedM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .advanceM     (advanceM),
        .readdataM    (readdataM),
        .stallM       (stallM),
        .adelM        (adelM),
        .adesM        (adesM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] sz);
        return (nbytes(sz) == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes(sz))) - 32'h1);
    endfunction

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic wr, input logic [1:0] sz, input logic [31:0] a);
        int v;
        if (!wr) return 4'h0;
        v = ((1 << nbytes(sz)) - 1) << int'(a[1:0]);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (nbytes(sz) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (nbytes(sz) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        mask = lane_mask(sz);
        v = (rd >> (8 * int'(a[1:0]))) & mask;
        if (!uns && nbytes(sz) < 4 && v[8 * nbytes(sz) - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (data_req && !prev_req) req_cnt++;
        prev_req = data_req;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stallM", 32'(stallM), 32'(m_stall));
            chk("data_req", 32'(data_req), 32'(m_req));
            chk("adelM", 32'(adelM), 32'(mem_enM & ~memwriteM & m_mis(sizeM, aluoutM)));
            chk("adesM", 32'(adesM), 32'(mem_enM & memwriteM & m_mis(sizeM, aluoutM)));
            if (m_req) begin
                chk("data_addr", data_addr, aluoutM);
                chk("data_wr", 32'(data_wr), 32'(memwriteM));
                chk("data_size", 32'(data_size), 32'(sizeM));
                chk("data_wstrb", 32'(data_wstrb), 32'(m_strb(memwriteM, sizeM, aluoutM)));
                if (memwriteM) chk("data_wdata", data_wdata, m_wdata(sizeM, writedataM));
                if (lit_wr_en) begin
                    chk("lit_wstrb", 32'(data_wstrb), 32'(lit_strb));
                    chk("lit_wdata", data_wdata, lit_wdata);
                end
            end
            if (m_rd_en) chk("readdataM", readdataM, m_rd);
            if (lit_rd_en) chk("lit_readdataM", readdataM, lit_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_enM = 1'b0; memwriteM = 1'b0; sizeM = 2'd2; unsignedM = 1'b0;
        aluoutM = 32'h0; writedataM = 32'h0; advanceM = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        m_stall = 1'b0; m_req = 1'b0; m_rd_en = 1'b0;
        lit_rd_en = 1'b0; lit_wr_en = 1'b0;
    endtask

    // One M-stage access: IDLE cycle, aok_dly+1 request cycles, dok_dly data-wait
    // cycles, then hold+1 completed cycles with advanceM on the last.
    task automatic do_access(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int aok_dly, input int dok_dly, input int hold,
                             input logic lit_en, input logic [31:0] lit_val, input logic [3:0] lit_s);
        int req0;
        req0 = req_cnt;
        mem_enM = 1'b1; memwriteM = wr; sizeM = sz; unsignedM = uns;
        aluoutM = a; writedataM = wd; advanceM = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'hA5A5_5A5A;
        m_rd_en = 1'b0; lit_rd_en = 1'b0; lit_wr_en = 1'b0;
        if (m_mis(sz, a)) begin
            m_stall = 1'b0; m_req = 1'b0;
            step();
            step();
            advanceM = 1'b1;
            step();
            idle_inputs();
            chk("req_count_fault", 32'(req_cnt - req0), 32'd0);
            return;
        end
        m_stall = 1'b1; m_req = 1'b0;
        step();
        m_req = 1'b1;
        lit_wr_en = lit_en & wr; lit_wdata = lit_val; lit_strb = lit_s;
        for (int i = 0; i <= aok_dly; i++) begin
            data_addr_ok = (i == aok_dly);
            data_data_ok = (i == aok_dly) && (dok_dly == 0);
            data_rdata   = data_data_ok ? rd : 32'hA5A5_5A5A;
            step();
        end
        data_addr_ok = 1'b0; m_req = 1'b0; lit_wr_en = 1'b0;
        for (int i = 1; i <= dok_dly; i++) begin
            data_data_ok = (i == dok_dly);
            data_rdata   = data_data_ok ? rd : 32'hA5A5_5A5A;
            step();
        end
        m_stall = 1'b0;
        m_rd_en = ~wr; m_rd = m_load(sz, uns, a, rd);
        lit_rd_en = lit_en & ~wr; lit_rd = lit_val;
        for (int i = 0; i <= hold; i++) begin
            data_data_ok = (i == 0) && (hold > 0);
            data_rdata   = ~rd;
            advanceM     = (i == hold);
            step();
        end
        idle_inputs();
        chk("req_count", 32'(req_cnt - req0), 32'd1);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        chk_en = 1'b1;
        lit_rd_en = 1'b1; lit_rd = 32'h0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        lit_rd_en = 1'b0;
        step();

        // sb to the top byte lane, same-cycle addr_ok/data_ok
        do_access(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 1,
                  1'b1, 32'hABAB_ABAB, 4'b1000);
        do_access(1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 1, 1,
                  1'b1, 32'hFFFF_FF80, 4'h0);
        do_access(1'b0, 2'd0, 1'b1, 32'h0000_2001, 32'h0, 32'h0000_8000, 1, 0, 0,
                  1'b1, 32'h0000_0080, 4'h0);
        do_access(1'b0, 2'd1, 1'b0, 32'h0000_3002, 32'h0, 32'hF00F_1234, 2, 2, 1,
                  1'b1, 32'hFFFF_F00F, 4'h0);

        // reset while waiting for data_ok
        mem_enM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2; aluoutM = 32'h0000_5000;
        m_stall = 1'b1; m_req = 1'b0;
        step();
        m_req = 1'b1; data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; m_req = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1; mem_enM = 1'b0;
        m_stall = 1'b0; m_req = 1'b0;
        lit_rd_en = 1'b1; lit_rd = 32'h0;
        step();
        rst = 1'b0;
        step();
        chk("req_after_reset", 32'(data_req), 32'd0);
        idle_inputs();

        // misaligned accesses fault without touching the bus
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0, 32'h0, 0, 0, 0, 1'b0, 32'h0, 4'h0);
        do_access(1'b1, 2'd2, 1'b0, 32'h0000_4001, 32'h1234_5678, 32'h0, 0, 0, 0, 1'b0, 32'h0, 4'h0);
        do_access(1'b1, 2'd1, 1'b0, 32'h0000_4003, 32'h1234_5678, 32'h0, 0, 0, 0, 1'b0, 32'h0, 4'h0);

        // completed lw held in DONE with a spurious data_ok
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0, 32'h1234_5678, 0, 1, 4,
                  1'b1, 32'h1234_5678, 4'h0);

        // back-to-back mix
        do_access(1'b1, 2'd2, 1'b0, 32'h0000_7004, 32'hCAFE_F00D, 32'h0, 1, 0, 0,
                  1'b1, 32'hCAFE_F00D, 4'b1111);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_7004, 32'h0, 32'hCAFE_F00D, 0, 0, 0,
                  1'b1, 32'hCAFE_F00D, 4'h0);
        do_access(1'b1, 2'd1, 1'b0, 32'h0000_7006, 32'h0000_BEEF, 32'h0, 0, 2, 0,
                  1'b1, 32'hBEEF_BEEF, 4'b1100);
        do_access(1'b0, 2'd1, 1'b1, 32'h0000_7006, 32'h0, 32'hBEEF_0000, 0, 0, 1,
                  1'b1, 32'h0000_BEEF, 4'h0);
        do_access(1'b0, 2'd0, 1'b0, 32'h0000_7002, 32'h0, 32'h0055_0000, 0, 0, 0,
                  1'b1, 32'h0000_0055, 4'h0);
        do_access(1'b0, 2'd3, 1'b0, 32'h0000_7008, 32'h0, 32'h8765_4321, 0, 0, 0,
                  1'b1, 32'h8765_4321, 4'h0);

        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
